// File: rtl/result_display_driver.sv
// Signed-product display driver: sequential double-dabble BCD conversion feeding a
// 4-digit multiplexed 7-segment scan with a sign LED.
module result_display_driver #(
  parameter int REFRESH_DIV = 27000,
  parameter int MAG_W       = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MAG_W-1:0] prod_i,
  input  logic             signo_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [3:0]       anodo_o,
  output logic [6:0]       seg_o,
  output logic             signo_o
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (MAG_W > 2) ? $clog2(MAG_W) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  state_t           state, state_nxt;
  logic [MAG_W-1:0] sh;
  logic [15:0]      bcd, bcd_adj;
  logic             ovf, sgn;
  logic [BW-1:0]    bit_cnt;
  logic [3:0][6:0]  dig;
  logic [CW-1:0]    cnt;
  logic [1:0]       idx, idx_nxt;
  logic             wrap;

  assign ready_o = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_i) state_nxt = CONV;
      CONV:    if (bit_cnt == '0) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // add-3 correction on every digit before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++)
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh      <= '0;
      bcd     <= '0;
      ovf     <= 1'b0;
      sgn     <= 1'b0;
      bit_cnt <= '0;
      dig     <= {4{SEG_BLANK}};
      signo_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid_i) begin
          sh      <= prod_i;
          sgn     <= signo_i;
          bcd     <= '0;
          ovf     <= 1'b0;
          bit_cnt <= BW'(MAG_W-1);
        end
        CONV: begin
          // bit leaving digit3 means the value no longer fits in four digits
          bcd     <= {bcd_adj[14:0], sh[MAG_W-1]};
          ovf     <= ovf | bcd_adj[15];
          sh      <= sh << 1;
          bit_cnt <= bit_cnt - 1'b1;
        end
        LOAD: begin
          if (ovf) begin
            dig     <= {4{SEG_DASH}};
            signo_o <= 1'b0;
          end else begin
            dig[0]  <= seg_of(bcd[3:0]);
            dig[1]  <= (bcd[15:4] == '0) ? SEG_BLANK : seg_of(bcd[7:4]);
            dig[2]  <= (bcd[15:8] == '0) ? SEG_BLANK : seg_of(bcd[11:8]);
            dig[3]  <= (bcd[15:12] == '0) ? SEG_BLANK : seg_of(bcd[15:12]);
            signo_o <= sgn & (bcd != '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign wrap    = (cnt == CW'(REFRESH_DIV-1));
  assign idx_nxt = wrap ? idx + 2'd1 : idx;

  // scan runs freely, independent of the conversion FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      anodo_o <= 4'b1110;
      seg_o   <= SEG_BLANK;
    end else begin
      cnt     <= wrap ? '0 : cnt + 1'b1;
      idx     <= idx_nxt;
      anodo_o <= ~(4'b0001 << idx_nxt);
      seg_o   <= dig[idx_nxt];
    end
  end
endmodule

// File: tb/tb_result_display_driver.sv
// Bench for result_display_driver: arithmetic display model checked every cycle plus
// literal digit expectations for the directed products.
module tb_result_display_driver;
  localparam int DIV = 4;
  localparam int MW  = 14;
  localparam int LAT = MW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [MW-1:0] prod_i = '0;
  logic          signo_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [3:0]    anodo_o;
  logic [6:0]    seg_o;
  logic          signo_o;

  result_display_driver #(.REFRESH_DIV(DIV), .MAG_W(MW)) dut (
    .clk(clk), .rst(rst), .prod_i(prod_i), .signo_i(signo_i), .valid_i(valid_i),
    .ready_o(ready_o), .anodo_o(anodo_o), .seg_o(seg_o), .signo_o(signo_o)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  function automatic logic [6:0] enc(input int d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return t[d];
  endfunction

  // what digit i must show for a magnitude, straight from the formatting rules
  function automatic logic [6:0] fmt(input int mag, input int i);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (mag > 9999) return DASH;
    if (i > 0 && mag < p) return BLANK;
    return enc((mag / p) % 10);
  endfunction

  // model: edges since reset, busy countdown, shown digits
  int         m_n, m_busy, m_mag;
  logic       m_sgn_p, m_sign;
  logic [6:0] m_disp [4];
  logic [6:0] m_seg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n <= 0; m_busy <= 0; m_mag <= 0; m_sgn_p <= 1'b0; m_sign <= 1'b0;
      m_seg <= BLANK;
      for (int i = 0; i < 4; i++) m_disp[i] <= BLANK;
    end else begin
      m_n   <= m_n + 1;
      m_seg <= m_disp[((m_n + 1) / DIV) % 4];
      if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          for (int i = 0; i < 4; i++) m_disp[i] <= fmt(m_mag, i);
          m_sign <= m_sgn_p && m_mag != 0 && m_mag <= 9999;
        end
      end else if (valid_i) begin
        m_busy  <= LAT;
        m_mag   <= int'(prod_i);
        m_sgn_p <= signo_i;
      end
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // one cycle; outputs compared against the model at the falling edge
  task automatic tick();
    logic [3:0] an_exp;
    @(negedge clk);
    if (!rst) begin
      an_exp = ~(4'b0001 << ((m_n / DIV) % 4));
      chk("ready", {31'b0, ready_o}, {31'b0, m_busy == 0});
      chk("anodo", {28'b0, anodo_o}, {28'b0, an_exp});
      chk("seg",   {25'b0, seg_o},   {25'b0, m_seg});
      chk("signo", {31'b0, signo_o}, {31'b0, m_sign});
    end
  endtask

  task automatic send(input int mag, input logic s);
    prod_i = MW'(mag); signo_i = s; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic wait_dig(input int i, input logic [6:0] exp, input string nm);
    logic [3:0] want;
    bit found;
    want = ~(4'b0001 << i);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (anodo_o == want) found = 1;
      else tick();
    end
    if (!found) chk({nm, "_timeout"}, {28'b0, anodo_o}, {28'b0, want});
    else        chk(nm, {25'b0, seg_o}, {25'b0, exp});
  endtask

  task automatic show4(input logic [6:0] d3, d2, d1, d0, input string nm);
    chk({nm, "_m3"}, {25'b0, m_disp[3]}, {25'b0, d3});
    chk({nm, "_m0"}, {25'b0, m_disp[0]}, {25'b0, d0});
    wait_dig(3, d3, {nm, "_d3"});
    wait_dig(2, d2, {nm, "_d2"});
    wait_dig(1, d1, {nm, "_d1"});
    wait_dig(0, d0, {nm, "_d0"});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    // 1) reset state and scan order
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    chk("rst_anodo", {28'b0, anodo_o}, 32'b1110);
    chk("rst_seg",   {25'b0, seg_o},   32'b1111111);
    chk("rst_signo", {31'b0, signo_o}, 32'd0);
    rst = 1'b0;
    repeat (4) tick();
    chk("scan1", {28'b0, anodo_o}, 32'b1101);
    repeat (4) tick();
    chk("scan2", {28'b0, anodo_o}, 32'b1011);
    repeat (4) tick();
    chk("scan3", {28'b0, anodo_o}, 32'b0111);
    repeat (4) tick();
    chk("scan0", {28'b0, anodo_o}, 32'b1110);

    // 2) 1234 negative
    send(1234, 1'b1);
    chk("busy", {31'b0, ready_o}, 32'd0);
    repeat (LAT + 2) tick();
    chk("sign1234", {31'b0, signo_o}, 32'd1);
    show4(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, "p1234");

    // 3) 7 positive
    send(7, 1'b0);
    repeat (LAT + 2) tick();
    chk("sign7", {31'b0, signo_o}, 32'd0);
    show4(BLANK, BLANK, BLANK, 7'b1111000, "p7");

    // 4) negative zero suppressed
    send(0, 1'b1);
    repeat (LAT + 2) tick();
    chk("sign0", {31'b0, signo_o}, 32'd0);
    show4(BLANK, BLANK, BLANK, 7'b1000000, "p0");

    // 5) overflow then 9801, plus boundaries 9999 / 10000
    send(12000, 1'b1);
    repeat (LAT + 2) tick();
    chk("signovf", {31'b0, signo_o}, 32'd0);
    show4(DASH, DASH, DASH, DASH, "p12000");
    send(9801, 1'b0);
    repeat (LAT + 2) tick();
    show4(7'b0010000, 7'b0000000, 7'b1000000, 7'b1111001, "p9801");
    send(9999, 1'b1);
    repeat (LAT + 2) tick();
    chk("sign9999", {31'b0, signo_o}, 32'd1);
    show4(7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000, "p9999");
    send(10000, 1'b0);
    repeat (LAT + 2) tick();
    show4(DASH, DASH, DASH, DASH, "p10000");
    send(16383, 1'b1);
    repeat (LAT + 2) tick();
    show4(DASH, DASH, DASH, DASH, "p16383");

    // 6) reset mid-conversion, then valid ignored while busy
    send(1234, 1'b1);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("mid_ready", {31'b0, ready_o}, 32'd1);
    chk("mid_anodo", {28'b0, anodo_o}, 32'b1110);
    chk("mid_seg",   {25'b0, seg_o},   32'b1111111);
    chk("mid_signo", {31'b0, signo_o}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (LAT + 2) tick();
    show4(BLANK, BLANK, BLANK, BLANK, "pblank");
    send(4321, 1'b0);
    repeat (3) tick();
    send(7, 1'b1);
    repeat (LAT + 2) tick();
    chk("ign_sign", {31'b0, signo_o}, 32'd0);
    show4(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, "p4321");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
